fetch_unit: RTL

Program-counter and instruction-register stage of the multicycle MIPS core. It holds the PC, the instruction register and the ALUOut holding register. It resolves next-PC selection and the conditional branch write from the controller's PCWE/PCSrc/Branch/BEQSel strobes. It sits between the unified memory/ALU datapath and the controller FSM: it consumes the FSM's sequencing controls and supplies the opcode/funct fields the FSM decodes.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_unit_next_pc_sel.sv | 53 +++++
 rtl/fetch_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants for the multicycle MIPS core: next-PC select codes,
// reset PC and instruction field positions used by fetch and controller.
package core_pkg;

    localparam logic [1:0]  PC_SRC_ALU    = 2'd0;
    localparam logic [1:0]  PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0]  PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0]  PC_SRC_JR     = 2'd3;

    localparam logic [31:0] RESET_PC      = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux and PC write qualification.
// Optional FETCH_ALIGN_CHECK_EN suppresses writes of unaligned targets
// and flags them.
module next_pc_sel
    import core_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [3:0]  pc_hi,
    input  logic [25:0] jump_idx,
    input  logic [31:0] rs_data,
    input  logic        pc_we,
    input  logic        branch,
    input  logic        beq_sel,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic        pc_load,
    output logic        misalign_evt
);

    logic pc_wr;

    // Select the candidate next PC.
    always_comb begin
        next_pc = alu_result;
        case (pc_src)
            PC_SRC_ALU:    next_pc = alu_result;
            PC_SRC_BRANCH: next_pc = alu_out;
            PC_SRC_JUMP:   next_pc = {pc_hi, jump_idx, 2'b00};
            PC_SRC_JR:     next_pc = rs_data;
            default:       next_pc = alu_result;
        endcase
    end

    // Unconditional write or a branch whose condition holds (beq_sel flips it for bne).
    assign pc_wr = pc_we | (branch & (alu_zero ^ beq_sel));

`ifdef FETCH_ALIGN_CHECK_EN
    // An unaligned target is reported and the write dropped so PC stays word-aligned.
    always_comb begin
        misalign_evt = pc_wr & (next_pc[1:0] != 2'b00);
        pc_load      = pc_wr & ~misalign_evt;
    end
`else
    // No alignment policing: every qualified write lands as-is.
    always_comb begin
        misalign_evt = 1'b0;
        pc_load      = pc_wr;
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and ALUOut holding register of the
// multicycle MIPS core. Optional macro FETCH_ALIGN_CHECK_EN enables the
// sticky pc_misalign fault and suppression of unaligned PC writes.
module fetch_unit
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_we,
    input  logic [1:0]  pc_src,
    input  logic        branch,
    input  logic        beq_sel,
    input  logic        ir_write,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext,
    output logic        ir_valid,
    output logic        pc_misalign
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        ir_valid_q, ir_valid_d;
    logic        pc_misalign_q, pc_misalign_d;

    logic [31:0] next_pc;
    logic        pc_load;
    logic        misalign_evt;

    next_pc_sel u_next_pc_sel (
        .pc_src       (pc_src),
        .alu_result   (alu_result),
        .alu_out      (alu_out_q),
        .pc_hi        (pc_q[31:28]),
        .jump_idx     (instr_q[25:0]),
        .rs_data      (rs_data),
        .pc_we        (pc_we),
        .branch       (branch),
        .beq_sel      (beq_sel),
        .alu_zero     (alu_zero),
        .next_pc      (next_pc),
        .pc_load      (pc_load),
        .misalign_evt (misalign_evt)
    );

    // Next-state for PC, IR, ALUOut and the sticky status bits.
    always_comb begin
        pc_d          = pc_load  ? next_pc   : pc_q;
        instr_d       = ir_write ? mem_rdata : instr_q;
        ir_valid_d    = ir_valid_q | ir_write;
        alu_out_d     = alu_result;
        pc_misalign_d = pc_misalign_q | misalign_evt;
    end

    // State registers; reset aborts any in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            alu_out_q     <= '0;
            ir_valid_q    <= 1'b0;
            pc_misalign_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            alu_out_q     <= alu_out_d;
            ir_valid_q    <= ir_valid_d;
            pc_misalign_q <= pc_misalign_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign alu_out     = alu_out_q;
    assign ir_valid    = ir_valid_q;
    assign pc_misalign = pc_misalign_q;

    // Decoded fields are pure slices of the IR.
    assign opcode   = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign rs       = instr_q[RS_MSB:RS_LSB];
    assign rt       = instr_q[RT_MSB:RT_LSB];
    assign rd       = instr_q[RD_MSB:RD_LSB];
    assign funct    = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign imm_sext = sext16(instr_q[IMM_MSB:IMM_LSB]);

endmodule
